pipe_elastic_chain: RTL and testbench

- Parametrised elastic pipeline register chain of DEPTH stages, each WIDTH bits wide, with a valid/ready handshake on both ends.
- Generalises the fixed IF/ID…MEM/WB pipeline registers into a single reusable block.
- Adds bubble collapsing, global stall, flush and occupancy tracking, which the fixed registers lack.
- Sits between producer and consumer stages of the pipelined computer, e.g. a multi-cycle EXE path or fetch buffer.

---
 rtl/pipe_elastic_chain.sv | 166 ++++++++++++++++
 tb/tb_pipe_elastic_chain.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_chain.sv
// pipe_elastic_chain: parametrised elastic register chain of DEPTH stages,
// WIDTH bits each, with valid/ready handshakes at both ends, bubble
// collapsing, global stall, flush and an occupancy counter.
// Optional feature macro: PIPE_SEQ_TAG_EN. When it is defined, each accepted
// item carries a TAGW-bit sequence tag, and the tag of the last stage is
// presented on out_seq.
module pipe_elastic_chain #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  parameter  int TAGW  = 4,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
`ifdef PIPE_SEQ_TAG_EN
  output logic [TAGW-1:0]  out_seq,
`endif
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNTW-1:0]  occupancy
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNTW-1:0]  occ_q, occ_d;
  logic [DEPTH-1:0] adv;
  logic             move_en;
  logic             in_xfer;
  logic             out_xfer;

`ifdef PIPE_SEQ_TAG_EN
  logic [TAGW-1:0]  tag_q [DEPTH];
  logic [TAGW-1:0]  tag_d [DEPTH];
  logic [TAGW-1:0]  seq_q, seq_d;
`endif

  // Stall and flush both freeze movement. A flush also blocks the output, so
  // nothing is handed downstream in the cycle where the contents are dropped.
  assign move_en   = !stall && !flush;
  assign out_valid = valid_q[DEPTH-1] && move_en;
  assign out_xfer  = out_valid && out_ready;
  assign in_ready  = move_en && (!valid_q[0] || adv[0]);
  assign in_xfer   = in_valid && in_ready;

  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;

  // Advance chain, resolved from the output stage back toward the input stage.
  always_comb begin
    logic down_adv;
    // NOTE: every variable written in always_comb is given a default before
    // any conditional update, so no path can leave it unassigned. An
    // unassigned path would infer a latch.
    adv          = '0;
    adv[DEPTH-1] = out_xfer;
    down_adv     = out_xfer;
    // NOTE: blocking '=' is used here on purpose. Each stage must see the
    // advance decision already made for the stage downstream of it in the
    // same pass. Clocked state always uses '<='.
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i]   = move_en && valid_q[i] && (!valid_q[i+1] || down_adv);
      down_adv = adv[i];
    end
  end

  // Next state of the stages: load from the upstream source, clear on a
  // drained advance, otherwise hold. Empty stages therefore keep filling
  // while the output is blocked.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef PIPE_SEQ_TAG_EN
    tag_d   = tag_q;
`endif
    if (in_xfer) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data;
`ifdef PIPE_SEQ_TAG_EN
      tag_d[0]   = seq_q;
`endif
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
`ifdef PIPE_SEQ_TAG_EN
        tag_d[i]   = tag_q[i-1];
`endif
      end else if (adv[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Occupancy counts input transfers minus output transfers. A flush empties
  // the chain.
  always_comb begin
    occ_d = occ_q;
    unique case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + CNTW'(1);
      2'b01:   occ_d = occ_q - CNTW'(1);
      default: occ_d = occ_q;
    endcase
    if (flush) begin
      occ_d = '0;
    end
  end

`ifdef PIPE_SEQ_TAG_EN
  // The sequence counter advances on every accepted item. Only reset clears
  // it, so items dropped by a flush show up as gaps in the tags.
  always_comb begin
    seq_d = in_xfer ? seq_q + TAGW'(1) : seq_q;
  end

  assign out_seq = tag_q[DEPTH-1];
`endif

  // State registers. Reset takes priority over flush and stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      // NOTE: the payload array is cleared on reset, which costs a reset on
      // every data flop. It is done because out_data must read 0 after reset.
      // A pure datapath array would normally be left without a reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      data_q  <= data_d;
    end
  end

`ifdef PIPE_SEQ_TAG_EN
  // Tag registers move in step with the payload registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      seq_q <= seq_d;
      tag_q <= tag_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Testbench for pipe_elastic_chain (DEPTH=3, WIDTH=32). Accepted inputs are
// pushed into a scoreboard queue, and a separate monitor pops and compares
// every output transfer. Directed checks cover the state after each phase.
// Define PIPE_SEQ_TAG_EN to also exercise the sequence tags.
module tb_pipe_elastic_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int TAGW  = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             stall;
  logic             flush;
  logic [DEPTH-1:0] stage_valid;
  logic [CNTW-1:0]  occupancy;
`ifdef PIPE_SEQ_TAG_EN
  logic [TAGW-1:0]  out_seq;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAGW-1:0]  tag;
  } exp_t;

  exp_t            sb_q[$];
  logic [TAGW-1:0] model_seq;

  pipe_elastic_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stall       (stall),
    .flush       (flush),
`ifdef PIPE_SEQ_TAG_EN
    .out_seq     (out_seq),
`endif
    .stage_valid (stage_valid),
    .occupancy   (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input side of the scoreboard. Records each accepted item with the tag it
  // should carry. A flush or reset drops everything in flight.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb_q.delete();
      model_seq = '0;
    end else if (flush) begin
      sb_q.delete();
    end else if (in_valid && in_ready) begin
      e.data = in_data;
      e.tag  = model_seq;
      sb_q.push_back(e);
      model_seq = model_seq + TAGW'(1);
    end
  end

  // Output monitor: every output transfer must match the oldest expected item.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'(out_data), 64'hdead_beef_dead_beef);
      end else begin
        e = sb_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
`ifdef PIPE_SEQ_TAG_EN
        check("out_seq", 64'(out_seq), 64'(e.tag));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits a bounded number of cycles for the scoreboard to drain.
  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
      tick();
    end
    @(negedge clock);
    check(name, 64'(sb_q.size()), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int first_ov;
    int exp_occ;

    // Watchdog so that the bench always terminates.
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    do_reset();

    // Reset state.
    @(negedge clock);
    check("rst_stage_valid", 64'(stage_valid), 64'd0);
    check("rst_occupancy",   64'(occupancy),   64'd0);
    check("rst_out_valid",   64'(out_valid),   64'd0);
    check("rst_out_data",    64'(out_data),    64'd0);
    check("rst_in_ready",    64'(in_ready),    64'd1);
    tick();

    // Fill with out_ready low.
    in_valid = 1'b1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("fill_stage_valid", 64'(stage_valid), 64'b111);
    check("fill_occupancy",   64'(occupancy),   64'd3);
    check("fill_in_ready",    64'(in_ready),    64'd0);
    check("fill_out_data",    64'(out_data),    64'h11);
    check("fill_out_valid",   64'(out_valid),   64'd1);
    tick();

    // Drain: three output transfers in order, then empty.
    out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clock);
    check("drain_occupancy", 64'(occupancy), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_sb_empty",  64'(sb_q.size()), 64'd0);
    tick();

    // Throughput: continuous streaming of 1..10.
    first_ov = 0;
    in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = WIDTH'(i);
      @(negedge clock);
      exp_occ = (i - 1 < 3) ? i - 1 : 3;
      check("tput_in_ready",  64'(in_ready),  64'd1);
      check("tput_occupancy", 64'(occupancy), 64'(exp_occ));
      if (out_valid && first_ov == 0) first_ov = i;
      tick();
    end
    in_valid = 1'b0;
    check("tput_first_out_cycle", 64'(first_ov), 64'd4);
    wait_empty("tput_sb_empty", 10);

    // Bubble collapse: A, two idle cycles, B, with out_ready low.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 32'hB; tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("bubble_stage_valid_a", 64'(stage_valid), 64'b101);
    tick();
    @(negedge clock);
    check("bubble_stage_valid_b", 64'(stage_valid), 64'b110);
    check("bubble_out_data",      64'(out_data),    64'hA);
    check("bubble_occupancy",     64'(occupancy),   64'd2);

    // Stall for two cycles while both ends are willing.
    tick();
    stall = 1'b1; in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("stall_out_valid", 64'(out_valid), 64'd0);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      tick();
    end
    @(negedge clock);
    check("stall_stage_valid", 64'(stage_valid), 64'b110);
    check("stall_occupancy",   64'(occupancy),   64'd2);
    check("stall_out_data",    64'(out_data),    64'hA);
    tick();

    // Flush together with stall.
    flush = 1'b1;
    @(negedge clock);
    check("flush_in_ready",  64'(in_ready),  64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("flush_occupancy",   64'(occupancy),   64'd0);
    check("flush_stage_valid", 64'(stage_valid), 64'd0);
    tick();

    // Chain is usable again after the flush.
    in_valid = 1'b1; in_data = 32'h55; tick();
    in_valid = 1'b0;
    wait_empty("post_flush_sb_empty", 10);

    // Reset in mid-operation, asserted together with stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; tick();
    in_data = 32'h88; tick();
    in_valid = 1'b0; reset = 1'b1; stall = 1'b1; tick();
    reset = 1'b0; stall = 1'b0;
    @(negedge clock);
    check("midrst_stage_valid", 64'(stage_valid), 64'd0);
    check("midrst_occupancy",   64'(occupancy),   64'd0);
    check("midrst_out_data",    64'(out_data),    64'd0);
    check("midrst_in_ready",    64'(in_ready),    64'd1);
    tick();

`ifdef PIPE_SEQ_TAG_EN
    // Tag wrap: 17 accepts produce tags 0..15 and then 0.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = WIDTH'(32'h100 + i);
      tick();
    end
    in_valid = 1'b0;
    wait_empty("tag_wrap_sb_empty", 10);

    // Tag gap: tags 0..5 accepted, 3..5 dropped by the flush, next tag is 6.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = WIDTH'(32'h200 + i);
      tick();
    end
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    in_valid = 1'b1; in_data = 32'h2FF; tick();
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clock);
      while (!out_valid && n < 10) begin
        n++;
        @(negedge clock);
      end
      check("tag_gap_out_valid", 64'(out_valid), 64'd1);
      check("tag_gap_out_seq",   64'(out_seq),   64'd6);
    end
    tick();
    wait_empty("tag_gap_sb_empty", 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
